sw_debounce: RTL



---
 rtl/sw_debounce.sv | 95 +++++++++
 1 files changed

// File: rtl/sw_debounce.sv
// sw_debounce
// Per-bit two-flop synchroniser followed by a counting debounce filter for
// mechanical board inputs (joystick, DIP and select switches). The filtered
// levels and their single-cycle edge events feed the GPIO input vector.
//
// Ports
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   in_i       raw asynchronous switch levels, 1 = switch on
//   bypass_i   1 = skip the filter, output follows the synchroniser
//   out_o      debounced level
//   rise_o     one-cycle pulse on out_o 0->1, per bit
//   fall_o     one-cycle pulse on out_o 1->0, per bit
//   changed_o  OR of all rise_o/fall_o bits
module sw_debounce #(
  parameter int unsigned       Width          = 16,
  parameter int unsigned       DebounceCycles = 200000,
  parameter logic [Width-1:0]  ResetValue     = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] in_i,
  input  logic             bypass_i,
  output logic [Width-1:0] out_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntTc = CntW'(DebounceCycles - 1);

  logic [Width-1:0] r_s1;
  logic [Width-1:0] r_s2;
  logic [Width-1:0] r_out;
  logic [Width-1:0] r_rise;
  logic [Width-1:0] r_fall;
  logic             r_changed;
  logic [CntW-1:0]  r_cnt [Width];

  logic [Width-1:0] w_out_nxt;
  logic [Width-1:0] w_rise_nxt;
  logic [Width-1:0] w_fall_nxt;
  logic [CntW-1:0]  w_cnt_nxt [Width];

  // A bit's count runs only while s2 disagrees with the output; any
  // agreeing cycle clears it, so only an unbroken run reaches terminal count.
  // Bypass takes the new level immediately and keeps the count at zero, so
  // leaving bypass always starts a fresh run.
  always_comb begin
    w_out_nxt = r_out;
    for (int i = 0; i < Width; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_out[i]) begin
        if (bypass_i || (r_cnt[i] == CntTc)) begin
          w_out_nxt[i] = r_s2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CntW'(1);
        end
      end
    end
    w_rise_nxt = w_out_nxt & ~r_out;
    w_fall_nxt = ~w_out_nxt & r_out;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1      <= ResetValue;
      r_s2      <= ResetValue;
      r_out     <= ResetValue;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < Width; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1      <= in_i;
      r_s2      <= r_s1;
      r_out     <= w_out_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_changed <= |(w_rise_nxt | w_fall_nxt);
      for (int i = 0; i < Width; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign out_o     = r_out;
  assign rise_o    = r_rise;
  assign fall_o    = r_fall;
  assign changed_o = r_changed;

endmodule
